// File: rtl/data_mem_if.sv
// Request/response bundle between the MEM stage and the data memory controller.
interface data_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              select;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, select
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, select
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// RV32 data memory with byte/half/word lanes, one request in flight, READ_LAT response latency.
// Optional MISALIGN_TRAP_EN: flag misaligned accesses instead of forcing alignment.
module data_mem_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int READ_LAT    = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    data_mem_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = 2;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0]  widx;
    logic [1:0]        off, off_eff;
    logic              is_half, is_word, err_n, accept;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata_rep, word_rd, lane_data, rdata_n;
    logic [15:0]       half_sel;
    logic [7:0]        byte_sel;

    logic              req_ready_q, rsp_valid_q, rsp_err_q, select_q;
    logic [DATA_W-1:0] rsp_rdata_q, hold_rdata;
    logic              hold_err, hold_load;
    logic              unused_addr;

    assign accept      = bus.req_valid & req_ready_q;
    assign unused_addr = ^{bus.req_addr[ADDR_W-1:IDX_W+2]};

    always_comb begin
        widx    = bus.req_addr[IDX_W+1:2];
        off     = bus.req_addr[1:0];
        is_word = bus.req_size[1];
        is_half = (bus.req_size == 2'd1);
`ifdef MISALIGN_TRAP_EN
        off_eff = off;
        err_n   = (is_half & off[0]) | (is_word & (off != 2'b00));
`else
        off_eff = is_word ? 2'b00 : (is_half ? {off[1], 1'b0} : off);
        err_n   = 1'b0;
`endif
        if (is_word) begin
            be        = 4'b1111;
            wdata_rep = bus.req_wdata;
        end else if (is_half) begin
            be        = off_eff[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{bus.req_wdata[15:0]}};
        end else begin
            be        = 4'b0001 << off_eff;
            wdata_rep = {4{bus.req_wdata[7:0]}};
        end
        if (err_n) be = '0;

        word_rd  = mem[widx];
        half_sel = off_eff[1] ? word_rd[31:16] : word_rd[15:0];
        byte_sel = word_rd[{off_eff, 3'b000} +: 8];
        if (is_word)
            lane_data = word_rd;
        else if (is_half)
            lane_data = bus.req_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
        else
            lane_data = bus.req_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        rdata_n = (bus.req_we | err_n) ? '0 : lane_data;
    end

    // Stores commit on the accept edge; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (rst_n && accept && bus.req_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            select_q    <= 1'b0;
            hold_rdata  <= '0;
            hold_err    <= 1'b0;
            hold_load   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    req_ready_q <= 1'b0;
                    hold_rdata  <= rdata_n;
                    hold_err    <= err_n;
                    hold_load   <= ~bus.req_we;
                    if (READ_LAT == 1) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rdata_n;
                        rsp_err_q   <= err_n;
                        select_q    <= ~bus.req_we;
                    end else begin
                        state <= ACCESS;
                        cnt   <= CNT_W'(READ_LAT > 1 ? READ_LAT - 2 : 0);
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= hold_rdata;
                        rsp_err_q   <= hold_err;
                        select_q    <= hold_load;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: if (bus.rsp_ready) begin
                    state       <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                    select_q    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.select    = select_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: a READ_LAT=1 and a READ_LAT=3 instance against a byte-array model.
module tb_data_mem_ctrl;
    localparam int D1 = 1024;
    localparam int D3 = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_if #(.DATA_W(32), .ADDR_W(32)) b1 ();
    data_mem_if #(.DATA_W(32), .ADDR_W(32)) b3 ();

    data_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(D1), .READ_LAT(1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    data_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(D3), .READ_LAT(3))
        dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    logic [7:0] m1 [4*D1];
    logic [7:0] m3 [4*D3];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input int which,
                                input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut%0d): got %h expected %h", name, which, act, exp);
        end
    endfunction

    // Reference: byte-addressed array, access width n, wrap by modulo.
    function automatic void model_op(input int which, input bit we, input logic [31:0] addr,
                                     input logic [1:0] size, input bit uns, input logic [31:0] wd,
                                     output logic [31:0] rd, output bit err);
        int unsigned n, span, base;
        logic [31:0] v;
        n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        span = (which == 1) ? 4*D1 : 4*D3;
        base = addr % span;
        err  = 1'b0;
        rd   = '0;
        if (base % n != 0) begin
`ifdef MISALIGN_TRAP_EN
            err = 1'b1;
            return;
`else
            base = base - (base % n);
`endif
        end
        if (we) begin
            for (int unsigned i = 0; i < n; i++) begin
                if (which == 1) m1[base+i] = wd[8*i +: 8];
                else            m3[base+i] = wd[8*i +: 8];
            end
        end else begin
            v = '0;
            for (int unsigned i = 0; i < n; i++)
                v = v | ({24'b0, (which == 1) ? m1[base+i] : m3[base+i]} << (8*i));
            if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
            rd = v;
        end
    endfunction

    task automatic drive(input int which, input bit v, input bit we, input logic [31:0] addr,
                         input logic [1:0] size, input bit uns, input logic [31:0] wd);
        if (which == 1) begin
            b1.req_valid = v; b1.req_we = we; b1.req_addr = addr;
            b1.req_size = size; b1.req_unsigned = uns; b1.req_wdata = wd;
        end else begin
            b3.req_valid = v; b3.req_we = we; b3.req_addr = addr;
            b3.req_size = size; b3.req_unsigned = uns; b3.req_wdata = wd;
        end
    endtask

    task automatic set_rready(input int which, input bit v);
        if (which == 1) b1.rsp_ready = v;
        else            b3.rsp_ready = v;
    endtask

    task automatic sample(input int which, output logic rv, output logic rr, output logic er,
                          output logic sel, output logic [31:0] rd);
        if (which == 1) begin
            rv = b1.rsp_valid; rr = b1.req_ready; er = b1.rsp_err; sel = b1.select; rd = b1.rsp_rdata;
        end else begin
            rv = b3.rsp_valid; rr = b3.req_ready; er = b3.rsp_err; sel = b3.select; rd = b3.rsp_rdata;
        end
    endtask

    task automatic xfer(input int which, input bit we, input logic [31:0] addr, input logic [1:0] size,
                        input bit uns, input logic [31:0] wd, input int hold, output logic [31:0] got);
        logic [31:0] exp_rd, rd;
        bit exp_err;
        logic rv, rr, er, sel;
        int lat, waitc, explat;
        explat = (which == 1) ? 1 : 3;
        @(negedge clk);
        sample(which, rv, rr, er, sel, rd);
        waitc = 0;
        while (!rr && waitc < 20) begin
            @(negedge clk);
            sample(which, rv, rr, er, sel, rd);
            waitc++;
        end
        chk("req_ready_idle", which, {31'b0, rr}, 32'd1);
        drive(which, 1'b1, we, addr, size, uns, wd);
        set_rready(which, hold == 0);
        model_op(which, we, addr, size, uns, wd, exp_rd, exp_err);
        @(posedge clk);
        #1 drive(which, 1'b0, 1'b0, '0, 2'd0, 1'b0, '0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            sample(which, rv, rr, er, sel, rd);
        end while (!rv && lat < 20);
        chk("latency", which, 32'(lat), 32'(explat));
        chk("rsp_rdata", which, rd, exp_rd);
        chk("rsp_err", which, {31'b0, er}, {31'b0, exp_err});
        chk("select", which, {31'b0, sel}, {31'b0, ~we});
        got = rd;
        for (int h = 0; h < hold; h++) begin
            chk("req_ready_busy", which, {31'b0, rr}, 32'd0);
            @(negedge clk);
            sample(which, rv, rr, er, sel, rd);
            chk("rsp_valid_held", which, {31'b0, rv}, 32'd1);
            chk("rsp_rdata_held", which, rd, exp_rd);
        end
        set_rready(which, 1'b1);
        @(negedge clk);
        sample(which, rv, rr, er, sel, rd);
        chk("rsp_valid_drop", which, {31'b0, rv}, 32'd0);
        chk("req_ready_back", which, {31'b0, rr}, 32'd1);
        chk("select_drop", which, {31'b0, sel}, 32'd0);
        set_rready(which, 1'b0);
    endtask

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    localparam logic [31:0] EXP_MIS = `ifdef MISALIGN_TRAP_EN 32'hAAAAAAAA `else 32'h55555555 `endif;

    initial begin
        vec_t tbl[$];
        logic [31:0] got, a;
        logic rv, rr, er, sel;
        logic [31:0] rd;

        tbl.push_back('{1'b1, 32'h10,   2'd2, 1'b0, 32'hDEADBEEF, 32'h0});
        tbl.push_back('{1'b0, 32'h10,   2'd2, 1'b0, 32'h0,        32'hDEADBEEF});
        tbl.push_back('{1'b1, 32'h20,   2'd2, 1'b0, 32'h11223344, 32'h0});
        tbl.push_back('{1'b1, 32'h21,   2'd0, 1'b0, 32'h00000080, 32'h0});
        tbl.push_back('{1'b0, 32'h20,   2'd2, 1'b0, 32'h0,        32'h11228044});
        tbl.push_back('{1'b0, 32'h21,   2'd0, 1'b0, 32'h0,        32'hFFFFFF80});
        tbl.push_back('{1'b0, 32'h21,   2'd0, 1'b1, 32'h0,        32'h00000080});
        tbl.push_back('{1'b1, 32'h23,   2'd0, 1'b0, 32'hFFFFFF7F, 32'h0});
        tbl.push_back('{1'b0, 32'h20,   2'd2, 1'b0, 32'h0,        32'h7F228044});
        tbl.push_back('{1'b1, 32'h30,   2'd2, 1'b0, 32'h01234567, 32'h0});
        tbl.push_back('{1'b1, 32'h32,   2'd1, 1'b0, 32'h0000BEEF, 32'h0});
        tbl.push_back('{1'b0, 32'h32,   2'd1, 1'b0, 32'h0,        32'hFFFFBEEF});
        tbl.push_back('{1'b0, 32'h32,   2'd1, 1'b1, 32'h0,        32'h0000BEEF});
        tbl.push_back('{1'b0, 32'h30,   2'd2, 1'b0, 32'h0,        32'hBEEF4567});
        tbl.push_back('{1'b0, 32'h30,   2'd3, 1'b0, 32'h0,        32'hBEEF4567});
        tbl.push_back('{1'b1, 32'h8,    2'd2, 1'b0, 32'hCAFEF00D, 32'h0});
        tbl.push_back('{1'b0, 32'h1008, 2'd2, 1'b0, 32'h0,        32'hCAFEF00D});
        tbl.push_back('{1'b1, 32'h40,   2'd2, 1'b0, 32'hAAAAAAAA, 32'h0});
        tbl.push_back('{1'b1, 32'h42,   2'd2, 1'b0, 32'h55555555, 32'h0});
        tbl.push_back('{1'b0, 32'h40,   2'd2, 1'b0, 32'h0,        EXP_MIS});

        drive(1, 1'b0, 1'b0, '0, 2'd0, 1'b0, '0);
        drive(3, 1'b0, 1'b0, '0, 2'd0, 1'b0, '0);
        set_rready(1, 1'b0);
        set_rready(3, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int w = 1; w <= 3; w += 2) begin
            sample(w, rv, rr, er, sel, rd);
            chk("reset_req_ready", w, {31'b0, rr}, 32'd1);
            chk("reset_rsp_valid", w, {31'b0, rv}, 32'd0);
            chk("reset_rsp_rdata", w, rd, 32'd0);
            chk("reset_rsp_err", w, {31'b0, er}, 32'd0);
            chk("reset_select", w, {31'b0, sel}, 32'd0);
        end
        rst_n = 1'b1;

        for (int w = 0; w < 64; w++) xfer(1, 1'b1, 32'(w*4), 2'd2, 1'b0, $urandom, 0, got);
        for (int w = 0; w < D3; w++) xfer(3, 1'b1, 32'(w*4), 2'd2, 1'b0, $urandom, 0, got);

        foreach (tbl[i]) begin
            xfer(1, tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wd, 0, got);
            chk("table_rdata", 1, got, tbl[i].exp);
        end

        // Slow consumer on the 3-cycle instance.
        xfer(3, 1'b1, 32'h8, 2'd2, 1'b0, 32'h0BADF00D, 0, got);
        xfer(3, 1'b0, 32'h8, 2'd2, 1'b0, 32'h0, 5, got);
        chk("hold_load_rdata", 3, got, 32'h0BADF00D);

        // Reset while a load sits in ACCESS.
        xfer(3, 1'b1, 32'h4, 2'd2, 1'b0, 32'h12345678, 0, got);
        @(negedge clk);
        drive(3, 1'b1, 1'b0, 32'h4, 2'd2, 1'b0, '0);
        @(posedge clk);
        #1 drive(3, 1'b0, 1'b0, '0, 2'd0, 1'b0, '0);
        @(negedge clk);
        sample(3, rv, rr, er, sel, rd);
        chk("access_busy", 3, {31'b0, rr}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        sample(3, rv, rr, er, sel, rd);
        chk("rst_mid_rsp_valid", 3, {31'b0, rv}, 32'd0);
        chk("rst_mid_req_ready", 3, {31'b0, rr}, 32'd1);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            sample(3, rv, rr, er, sel, rd);
            chk("rst_no_stale_rsp", 3, {31'b0, rv}, 32'd0);
        end
        xfer(3, 1'b0, 32'h4, 2'd2, 1'b0, 32'h0, 0, got);
        chk("rst_store_kept", 3, got, 32'h12345678);

        for (int i = 0; i < 150; i++) begin
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
            xfer(1, 1'($urandom), a, 2'($urandom), 1'($urandom), $urandom, $urandom_range(0, 2), got);
        end
        for (int i = 0; i < 80; i++) begin
            a = ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, 63));
            xfer(3, 1'($urandom), a, 2'($urandom), 1'($urandom), $urandom, $urandom_range(0, 2), got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
